// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset datapath: sequences each instruction and drives all datapath controls.
// Optional feature: define MC_CTRL_BNE_EN to decode bne (op 000101) as an inverted-condition branch.
module mc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       ir_we,
    output logic       mem_we,
    output logic       reg_we,
    output logic       iord,
    output logic       mem2reg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] aluctl,
    output logic [1:0] pcsrc,
    output logic       extop,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXE  = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IMMEXE = 4'd9,
        S_IMMWB  = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CTRL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t state_q, state_d;
    state_t out_state;
    logic   dec_illegal;
    logic   pc_we_c, ir_we_c, mem_we_c, reg_we_c;

    function automatic logic funct_legal(input logic [5:0] f);
        return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
               (f == 6'b100101) || (f == 6'b101010);
    endfunction

    function automatic logic [2:0] rtype_aluctl(input logic [5:0] f);
        case (f)
            6'b100010: return ALU_SUB;
            6'b100100: return ALU_AND;
            6'b100101: return ALU_OR;
            6'b101010: return ALU_SLT;
            default:   return ALU_ADD;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        dec_illegal = 1'b0;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE: begin
                        if (funct_legal(funct)) begin
                            state_d = S_RTEXE;
                        end else begin
                            state_d     = S_FETCH;
                            dec_illegal = 1'b1;
                        end
                    end
                    OP_BEQ:                    state_d = S_BRANCH;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:                    state_d = S_BRANCH;
`endif
                    OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_IMMEXE;
                    OP_J:                      state_d = S_JUMP;
                    default: begin
                        // PC already advanced in FETCH, so returning to FETCH skips the word.
                        state_d     = S_FETCH;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_RTEXE:  state_d = S_ALUWB;
            S_BRANCH: state_d = S_FETCH;
            S_IMMEXE: state_d = S_IMMWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // During reset the datapath sees FETCH controls with every write suppressed.
    always_comb begin
        out_state = rst ? S_FETCH : state_q;
        pc_we_c   = 1'b0;
        ir_we_c   = 1'b0;
        mem_we_c  = 1'b0;
        reg_we_c  = 1'b0;
        iord      = 1'b0;
        mem2reg   = 1'b0;
        regdst    = 1'b0;
        alusrca   = 1'b0;
        alusrcb   = 2'b00;
        aluctl    = 3'b000;
        pcsrc     = 2'b00;
        extop     = 1'b0;
        case (out_state)
            S_FETCH: begin
                alusrcb = 2'b01;
                aluctl  = ALU_ADD;
                ir_we_c = mem_ready;
                pc_we_c = mem_ready;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                aluctl  = ALU_ADD;
                extop   = 1'b1;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluctl  = ALU_ADD;
                extop   = 1'b1;
            end
            S_MEMRD:  iord = 1'b1;
            S_MEMWB: begin
                reg_we_c = 1'b1;
                mem2reg  = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                mem_we_c = 1'b1;
            end
            S_RTEXE: begin
                alusrca = 1'b1;
                aluctl  = rtype_aluctl(funct);
            end
            S_ALUWB: begin
                reg_we_c = 1'b1;
                regdst   = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluctl  = ALU_SUB;
                pcsrc   = 2'b01;
`ifdef MC_CTRL_BNE_EN
                pc_we_c = (op == OP_BNE) ? ~zero : zero;
`else
                pc_we_c = zero;
`endif
            end
            S_IMMEXE: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                case (op)
                    OP_ANDI: aluctl = ALU_AND;
                    OP_ORI:  aluctl = ALU_OR;
                    default: begin
                        aluctl = ALU_ADD;
                        extop  = 1'b1;
                    end
                endcase
            end
            S_IMMWB:  reg_we_c = 1'b1;
            S_JUMP: begin
                pcsrc   = 2'b10;
                pc_we_c = 1'b1;
            end
            default: ;
        endcase
    end

    assign pc_we   = pc_we_c  & ~rst;
    assign ir_we   = ir_we_c  & ~rst;
    assign mem_we  = mem_we_c & ~rst;
    assign reg_we  = reg_we_c & ~rst;
    assign illegal = dec_illegal & ~rst;
    assign state   = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: instruction-level reference model plus directed scenarios and random traffic.
// Honours MC_CTRL_BNE_EN the same way the design does.
module tb_mc_ctrl;

    typedef int iq_t[$];

    logic       clk = 1'b0;
    logic       rst, zero, mem_ready;
    logic [5:0] op, funct;
    logic       pc_we, ir_we, mem_we, reg_we, iord, mem2reg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] aluctl;
    logic       extop, illegal;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;
    int idx    = 0;
    bit mvalid = 1'b0;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101;
    localparam logic [5:0] JMP = 6'b000010;

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_we(pc_we), .ir_we(ir_we), .mem_we(mem_we), .reg_we(reg_we), .iord(iord),
        .mem2reg(mem2reg), .regdst(regdst), .alusrca(alusrca), .alusrcb(alusrcb),
        .aluctl(aluctl), .pcsrc(pcsrc), .extop(extop), .illegal(illegal), .state(state)
    );

    wire [20:0] dut_vec = {pc_we, ir_we, mem_we, reg_we, iord, mem2reg, regdst, alusrca,
                           alusrcb, aluctl, pcsrc, extop, illegal, state};

    // The sequence of states an instruction walks through, from its FETCH onward.
    function automatic iq_t seq_of(input logic [5:0] o, input logic [5:0] f);
        case (o)
            LW:   return '{0, 1, 2, 3, 4};
            SW:   return '{0, 1, 2, 5};
            RT: begin
                if (f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010})
                    return '{0, 1, 6, 7};
                return '{0, 1};
            end
            BEQ:  return '{0, 1, 8};
`ifdef MC_CTRL_BNE_EN
            BNE:  return '{0, 1, 8};
`endif
            ADDI, ANDI, ORI: return '{0, 1, 9, 10};
            JMP:  return '{0, 1, 11};
            default: return '{0, 1};
        endcase
    endfunction

    function automatic logic [20:0] exp_vec(input int st, input logic [5:0] o, input logic [5:0] f,
                                            input logic z, input logic mr, input logic r);
        logic pw, iw, mw, rw, io, m2r, rd, sa, ext, ill;
        logic [1:0] sb, ps;
        logic [2:0] ac;
        iq_t s;
        int d;
        {pw, iw, mw, rw, io, m2r, rd, sa, ext, ill} = '0;
        sb = 2'd0; ps = 2'd0; ac = 3'd0;
        d = r ? 0 : st;
        case (d)
            0:  begin sb = 2'b01; ac = 3'b010; iw = mr; pw = mr; end
            1:  begin sb = 2'b11; ac = 3'b010; ext = 1'b1; s = seq_of(o, f); ill = (s.size() == 2); end
            2:  begin sa = 1'b1; sb = 2'b10; ac = 3'b010; ext = 1'b1; end
            3:  io = 1'b1;
            4:  begin rw = 1'b1; m2r = 1'b1; end
            5:  begin io = 1'b1; mw = 1'b1; end
            6:  begin
                sa = 1'b1;
                case (f)
                    6'b100010: ac = 3'b110;
                    6'b100100: ac = 3'b000;
                    6'b100101: ac = 3'b001;
                    6'b101010: ac = 3'b111;
                    default:   ac = 3'b010;
                endcase
            end
            7:  begin rw = 1'b1; rd = 1'b1; end
            8:  begin sa = 1'b1; ac = 3'b110; ps = 2'b01; pw = (o == BNE) ? !z : z; end
            9:  begin
                sa = 1'b1; sb = 2'b10;
                if (o == ANDI) ac = 3'b000;
                else if (o == ORI) ac = 3'b001;
                else begin ac = 3'b010; ext = 1'b1; end
            end
            10: rw = 1'b1;
            11: begin ps = 2'b10; pw = 1'b1; end
            default: ;
        endcase
        if (r) {pw, iw, mw, rw, ill} = '0;
        return {pw, iw, mw, rw, io, m2r, rd, sa, sb, ac, ps, ext, ill, 4'(st)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic r, input logic [5:0] o, input logic [5:0] f,
                          input logic z, input logic mr);
        iq_t s;
        rst = r; op = o; funct = f; zero = z; mem_ready = mr;
        #1;
        if (mvalid) begin
            s = seq_of(op, funct);
            chk("model", 32'(dut_vec), 32'(exp_vec(s[idx], op, funct, zero, mem_ready, rst)));
        end
    endtask

    task automatic edge_step();
        iq_t s;
        int st;
        @(posedge clk);
        s  = seq_of(op, funct);
        st = s[idx];
        if (rst) begin
            idx = 0;
            mvalid = 1'b1;
        end else if (!((st == 0 || st == 3 || st == 5) && !mem_ready)) begin
            idx = (idx + 1) % s.size();
        end
        #1;
    endtask

    task automatic run_count(input string name, input logic [5:0] o, input logic [5:0] f,
                             input int expect_n);
        int n = 0;
        do begin
            set_in(1'b0, o, f, 1'b1, 1'b1);
            edge_step();
            n++;
        end while (state != 4'd0 && n < 20);
        chk(name, n, expect_n);
    endtask

    initial begin
        int lw_st[6];
        int sw_mr[6];
        int cnt;
        lw_st = '{0, 1, 2, 3, 4, 0};
        sw_mr = '{1, 1, 1, 0, 0, 1};

        set_in(1'b1, RT, 6'b100000, 1'b0, 1'b1);
        edge_step();
        set_in(1'b1, LW, 6'd0, 1'b0, 1'b1);
        chk("rst_state", state, 0);
        chk("rst_pc_we", pc_we, 0);
        chk("rst_ir_we", ir_we, 0);
        chk("rst_alusrcb", alusrcb, 2'b01);
        edge_step();

        for (int i = 0; i < 6; i++) begin
            set_in(1'b0, LW, 6'd0, 1'b0, 1'b1);
            chk("lw_state", state, lw_st[i]);
            chk("lw_reg_we", reg_we, (i == 4));
            chk("lw_mem2reg", mem2reg, (i == 4));
            chk("lw_extop", extop, (i == 1 || i == 2));
            if (i < 5) edge_step();
        end

        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            set_in(1'b0, SW, 6'd0, 1'b0, sw_mr[i][0]);
            cnt += int'(mem_we);
            edge_step();
        end
        set_in(1'b0, SW, 6'd0, 1'b0, 1'b1);
        chk("sw_mem_we_cycles", cnt, 3);
        chk("sw_back_fetch", state, 0);

        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, RT, 6'b101010, 1'b0, 1'b1);
            if (i == 2) chk("slt_aluctl", aluctl, 3'b111);
            if (i == 3) chk("slt_regdst", regdst, 1);
            edge_step();
        end
        cnt = 0;
        for (int i = 0; i < 2; i++) begin
            set_in(1'b0, RT, 6'b000111, 1'b0, 1'b1);
            cnt += int'(reg_we);
            chk("bad_funct_illegal", illegal, (i == 1));
            edge_step();
        end
        set_in(1'b0, RT, 6'b000111, 1'b0, 1'b1);
        chk("bad_funct_fetch", state, 0);
        chk("bad_funct_no_reg_we", cnt, 0);

        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, ANDI, 6'd0, 1'b0, 1'b1);
            if (i == 2) begin
                chk("andi_extop", extop, 0);
                chk("andi_aluctl", aluctl, 3'b000);
            end
            edge_step();
        end
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, ADDI, 6'd0, 1'b0, 1'b1);
            if (i == 2) begin
                chk("addi_extop", extop, 1);
                chk("addi_aluctl", aluctl, 3'b010);
            end
            edge_step();
        end

        for (int z = 1; z >= 0; z--) begin
            for (int i = 0; i < 3; i++) begin
                set_in(1'b0, BEQ, 6'd0, z[0], 1'b1);
                if (i == 2) begin
                    chk("beq_pc_we", pc_we, z[0]);
                    chk("beq_pcsrc", pcsrc, 2'b01);
                end
                edge_step();
            end
        end
`ifdef MC_CTRL_BNE_EN
        for (int z = 1; z >= 0; z--) begin
            for (int i = 0; i < 3; i++) begin
                set_in(1'b0, BNE, 6'd0, z[0], 1'b1);
                if (i == 2) chk("bne_pc_we", pc_we, !z[0]);
                edge_step();
            end
        end
`else
        for (int i = 0; i < 2; i++) begin
            set_in(1'b0, BNE, 6'd0, 1'b0, 1'b1);
            chk("bne_illegal", illegal, (i == 1));
            edge_step();
        end
`endif

        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, SW, 6'd0, 1'b0, 1'b1);
            edge_step();
        end
        set_in(1'b0, SW, 6'd0, 1'b0, 1'b0);
        chk("memwr_mem_we", mem_we, 1);
        edge_step();
        set_in(1'b1, SW, 6'd0, 1'b0, 1'b0);
        chk("rst_in_memwr_state", state, 5);
        chk("rst_in_memwr_mem_we", mem_we, 0);
        edge_step();
        set_in(1'b0, SW, 6'd0, 1'b0, 1'b0);
        chk("rst_in_memwr_fetch", state, 0);

        run_count("cyc_lw", LW, 6'd0, 5);
        run_count("cyc_sw", SW, 6'd0, 4);
        run_count("cyc_rtype", RT, 6'b100010, 4);
        run_count("cyc_ori", ORI, 6'd0, 4);
        run_count("cyc_beq", BEQ, 6'd0, 3);
        run_count("cyc_j", JMP, 6'd0, 3);
        run_count("cyc_illegal", 6'b111111, 6'd0, 2);

        begin
            logic [5:0] ops[10];
            logic [5:0] fns[6];
            logic [5:0] cur_op, cur_fn;
            ops = '{LW, SW, RT, BEQ, BNE, ADDI, ANDI, ORI, JMP, 6'd0};
            fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'd0};
            cur_op = LW;
            cur_fn = 6'd0;
            for (int c = 0; c < 4000; c++) begin
                if (idx == 0) begin
                    cur_op = ops[$urandom_range(0, 9)];
                    if (cur_op == 6'd0 && $urandom_range(0, 3) == 0) cur_op = 6'($urandom);
                    cur_fn = fns[$urandom_range(0, 5)];
                    if (cur_fn == 6'd0) cur_fn = 6'($urandom);
                end
                set_in(($urandom_range(0, 63) == 0), cur_op, cur_fn, 1'($urandom),
                       ($urandom_range(0, 3) != 0));
                edge_step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control FSM for the team's MIPS-subset datapath. It sequences fetch, decode, execute, memory and write-back for each instruction and drives every datapath enable and mux select, including `extop` to the sign/zero-extension unit. It stalls on a memory ready handshake and flags unsupported encodings. It sits between the instruction register (`op` and `funct` fields) and the shared ALU, register file, PC and unified memory.

## Interface
- No parameters.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `op` in 6: IR[31:26]. Stable from the cycle after the IR is written until the next fetch.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag from the current cycle.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_we` out 1: PC write enable.
- `ir_we` out 1: IR write enable.
- `mem_we` out 1: memory write request.
- `reg_we` out 1: register-file write enable.
- `iord` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `mem2reg` out 1: write-back data select. 1 = MDR, 0 = ALUOut.
- `regdst` out 1: destination register select. 1 = rd, 0 = rt.
- `alusrca` out 1: ALU A select. 0 = PC, 1 = rs.
- `alusrcb` out 2: ALU B select. 00 = rt, 01 = constant 4, 10 = ext(imm), 11 = ext(imm)<<2.
- `aluctl` out 3: ALU operation. 010 = add, 110 = sub, 000 = and, 001 = or, 111 = slt.
- `pcsrc` out 2: PC source select. 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `extop` out 1: extension mode. 1 = sign-extend, 0 = zero-extend.
- `illegal` out 1: one-cycle pulse on an unsupported op or funct.
- `state` out 4: current state, for debug.

## Operation
- State encoding:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5.
  - RTEXE = 6, ALUWB = 7, BRANCH = 8, IMMEXE = 9, IMMWB = 10, JUMP = 11.
- Outputs are combinational from `state` (plus `mem_ready`, `zero`, `op` and `funct` where noted). Every output not listed for a state is 0.
- FETCH:
  - `alusrcb` = 01, `aluctl` = 010.
  - `ir_we` = `pc_we` = `mem_ready`.
  - Stays in FETCH while `mem_ready` = 0; goes to DECODE when it is 1.
- DECODE:
  - `alusrcb` = 11, add, `extop` = 1 (precomputes the branch target).
  - Next state by `op`:
    - 100011 (lw) or 101011 (sw) → MEMADR.
    - 000000 → RTEXE.
    - 000100 (beq) → BRANCH.
    - 001000 (addi), 001100 (andi) or 001101 (ori) → IMMEXE.
    - 000010 (j) → JUMP.
  - Any other `op`, or `op` = 0 with `funct` outside {100000, 100010, 100100, 100101, 101010}: `illegal` = 1, next state FETCH. The PC already holds PC+4, so execution skips the instruction.
- MEMADR: `alusrca` = 1, `alusrcb` = 10, add, `extop` = 1. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: `iord` = 1. Waits for `mem_ready`, then goes to MEMWB.
- MEMWB: `reg_we` = 1, `mem2reg` = 1, `regdst` = 0. Next state FETCH.
- MEMWR: `iord` = 1, `mem_we` = 1, held until the cycle `mem_ready` = 1. Next state FETCH.
- RTEXE: `alusrca` = 1, `alusrcb` = 00, `aluctl` from `funct`:
  - add = 010, sub = 110, and = 000, or = 001, slt = 111.
  - Next state ALUWB.
- ALUWB: `reg_we` = 1, `regdst` = 1. Next state FETCH.
- BRANCH: `alusrca` = 1, `alusrcb` = 00, `aluctl` = 110, `pcsrc` = 01, `pc_we` = `zero`. Next state FETCH.
- IMMEXE: `alusrca` = 1, `alusrcb` = 10.
  - addi: add, `extop` = 1.
  - andi: `aluctl` = 000, `extop` = 0.
  - ori: `aluctl` = 001, `extop` = 0.
  - Next state IMMWB.
- IMMWB: `reg_we` = 1, `regdst` = 0, `mem2reg` = 0. Next state FETCH.
- JUMP: `pcsrc` = 10, `pc_we` = 1. Next state FETCH.

## Timing
- Reset:
  - `rst` = 1 at a rising edge sets state to FETCH.
  - While `rst` = 1, `pc_we`, `ir_we`, `mem_we`, `reg_we` and `illegal` are forced to 0 regardless of state. All other outputs take their FETCH values.
  - Reset mid-instruction abandons the instruction; no further writes are issued for it.
- Cycle counts with `mem_ready` held at 1, counted from entry into FETCH:
  - lw: 5. sw: 4. R-type: 4. addi/andi/ori: 4. beq: 3. j: 3. illegal: 2.
- Each cycle with `mem_ready` = 0 in FETCH, MEMRD or MEMWR adds exactly one cycle. Write enables for that access stay 0 (FETCH) or held (`mem_we`) until the ready cycle.
- `mem_ready` is ignored in every state other than FETCH, MEMRD and MEMWR.
- `illegal` is high for exactly one cycle (DECODE).

## Configuration
- `MC_CTRL_BNE_EN`:
  - Defined: `op` = 000101 (bne) decodes to BRANCH with `pc_we` = ~`zero`, 3 cycles.
  - Undefined: 000101 is illegal.

## Test plan
- Reset, then a lw with `mem_ready` always 1 → states 0, 1, 2, 3, 4, 0. `reg_we` = `mem2reg` = 1 only in state 4. `extop` = 1 in states 1 and 2.
- sw with `mem_ready` low for 2 cycles in MEMWR → `mem_we` = 1 for 3 consecutive cycles, and the FSM returns to FETCH after the third.
- R-type with `funct` = 101010, then `funct` = 000111 → first instruction: `aluctl` = 111 in RTEXE, `regdst` = 1 in ALUWB. Second instruction: `illegal` pulses in DECODE, then FETCH, with no `reg_we`.
- andi then addi → in IMMEXE: andi gives `extop` = 0, `aluctl` = 000; addi gives `extop` = 1, `aluctl` = 010.
- beq with `zero` = 1, then with `zero` = 0 → `pc_we` = 1 and 0 respectively in BRANCH, `pcsrc` = 01. With `MC_CTRL_BNE_EN` defined, op 000101 gives the inverse.
- `rst` asserted while in MEMWR with `mem_we` = 1 → `mem_we` = 0 that same cycle, and state = FETCH on the next edge.
